qft_stream_engine: RTL and testbench

//  Parametrised, sequential N-point quantum Fourier transform (complex DFT) over signed fixed-point amplitudes.

---
 rtl/qft_stream_engine.sv | 214 +++++++++++++++++++++
 tb/tb_qft_stream_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qft_stream_engine.sv
// qft_stream_engine: sequential N-point complex DFT (QFT) over a valid/ready stream.
// One complex MAC per cycle, products registered ahead of the accumulator.
module qft_stream_engine #(
  parameter int LOG2N = 2,
  parameter int IN_W  = 8,
  parameter int OUT_W = 13,
  parameter int TW_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  input  logic                    mode_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic [LOG2N-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_sat
);
  localparam int N     = 1 << LOG2N;
  localparam int CW    = 2 * LOG2N + 1;
  localparam int ACC_W = IN_W + TW_W + LOG2N + 1;
  localparam int SHIFT = TW_W - 2;
  localparam int S     = 1 << SHIFT;
  // round(S / sqrt(2)) using a 16-bit fractional constant
  localparam int C45   = int'((longint'(S) * 46341 + 32768) >>> 16);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (TW_W - 3));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(1 << (OUT_W - 1)));

  // cos of e*45 degrees scaled by S; sin is cos shifted by six octants
  function automatic int cos8(input int e);
    case (e & 7)
      0:       return S;
      1:       return C45;
      2:       return 0;
      3:       return -C45;
      4:       return -S;
      5:       return -C45;
      6:       return 0;
      default: return C45;
    endcase
  endfunction

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
  state_t state, state_next;

  logic signed [TW_W-1:0] rom_cos [N];
  logic signed [TW_W-1:0] rom_sin [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rom
      assign rom_cos[gi] = TW_W'(cos8(gi << (3 - LOG2N)));
      assign rom_sin[gi] = TW_W'(cos8((gi << (3 - LOG2N)) + 6));
    end
  endgenerate

  logic [LOG2N-1:0]        n_cnt;
  logic [CW-1:0]           cnt;
  logic                    mode;
  logic signed [IN_W-1:0]  x_re [N];
  logic signed [IN_W-1:0]  x_im [N];
  logic signed [OUT_W-1:0] res_re [N];
  logic signed [OUT_W-1:0] res_im [N];
  logic                    res_sat [N];

  logic             accept, issue, compute_done, out_fire;
  logic [LOG2N-1:0] k_cur, n_cur, tw_idx, next_idx;

  assign in_ready     = (state == LOAD);
  assign accept       = in_valid && in_ready;
  assign k_cur        = cnt[2*LOG2N-1:LOG2N];
  assign n_cur        = cnt[LOG2N-1:0];
  assign tw_idx       = k_cur * n_cur;  // truncation to LOG2N bits is the mod N
  assign issue        = (state == COMPUTE) && !cnt[CW-1];
  assign compute_done = (state == COMPUTE) && cnt[CW-1];
  assign out_fire     = (state == OUTPUT) && out_valid && out_ready;
  assign next_idx     = out_idx + LOG2N'(1);

  logic signed [ACC_W-1:0] a_re, a_im, w_re, w_im, mac_re, mac_im;
  assign a_re   = ACC_W'(x_re[n_cur]);
  assign a_im   = ACC_W'(x_im[n_cur]);
  assign w_re   = ACC_W'(rom_cos[tw_idx]);
  assign w_im   = mode ? ACC_W'(rom_sin[tw_idx]) : -ACC_W'(rom_sin[tw_idx]);
  assign mac_re = a_re * w_re - a_im * w_im;
  assign mac_im = a_re * w_im + a_im * w_re;

  logic signed [ACC_W-1:0] prod_re, prod_im, acc_re, acc_im;
  logic signed [ACC_W-1:0] sum_re, sum_im, rnd_re, rnd_im;
  logic                    prod_valid, prod_end;
  logic [LOG2N-1:0]        prod_k;
  logic signed [OUT_W-1:0] clip_re, clip_im;
  logic                    clip_any;

  assign sum_re = acc_re + prod_re;
  assign sum_im = acc_im + prod_im;
  assign rnd_re = (sum_re + RND_HALF) >>> SHIFT;
  assign rnd_im = (sum_im + RND_HALF) >>> SHIFT;

  always_comb begin
    clip_re  = rnd_re[OUT_W-1:0];
    clip_im  = rnd_im[OUT_W-1:0];
    clip_any = 1'b0;
    if (rnd_re > SAT_MAX) begin
      clip_re  = SAT_MAX[OUT_W-1:0];
      clip_any = 1'b1;
    end else if (rnd_re < SAT_MIN) begin
      clip_re  = SAT_MIN[OUT_W-1:0];
      clip_any = 1'b1;
    end
    if (rnd_im > SAT_MAX) begin
      clip_im  = SAT_MAX[OUT_W-1:0];
      clip_any = 1'b1;
    end else if (rnd_im < SAT_MIN) begin
      clip_im  = SAT_MIN[OUT_W-1:0];
      clip_any = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept && n_cnt == LOG2N'(N - 1)) state_next = COMPUTE;
      COMPUTE: if (compute_done) state_next = OUTPUT;
      OUTPUT:  if (out_fire && out_last) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cnt      <= '0;
      cnt        <= '0;
      mode       <= 1'b0;
      prod_valid <= 1'b0;
      prod_end   <= 1'b0;
      prod_k     <= '0;
      prod_re    <= '0;
      prod_im    <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_sat    <= 1'b0;
    end else begin
      if (accept) begin
        n_cnt <= n_cnt + LOG2N'(1);
        if (n_cnt == '0) mode <= mode_inv;
      end
      if (state == COMPUTE) cnt <= compute_done ? '0 : cnt + CW'(1);

      prod_valid <= issue;
      if (issue) begin
        prod_re  <= mac_re;
        prod_im  <= mac_im;
        prod_end <= (n_cur == LOG2N'(N - 1));
        prod_k   <= k_cur;
      end
      if (prod_valid) begin
        acc_re <= prod_end ? '0 : sum_re;
        acc_im <= prod_end ? '0 : sum_im;
      end

      // compute_done coincides with the final accumulate, which writes k=N-1, never k=0
      if (compute_done) begin
        out_valid <= 1'b1;
        out_idx   <= '0;
        out_re    <= res_re[0];
        out_im    <= res_im[0];
        out_sat   <= res_sat[0];
        out_last  <= 1'b0;
      end else if (out_fire) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          out_idx  <= next_idx;
          out_re   <= res_re[next_idx];
          out_im   <= res_im[next_idx];
          out_sat  <= res_sat[next_idx];
          out_last <= (next_idx == LOG2N'(N - 1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_re[n_cnt] <= in_re;
      x_im[n_cnt] <= in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (prod_valid && prod_end) begin
      res_re[prod_k]  <= clip_re;
      res_im[prod_k]  <= clip_im;
      res_sat[prod_k] <= clip_any;
    end
  end
endmodule

// File: tb/tb_qft_stream_engine.sv
// Scoreboard bench for qft_stream_engine: three instances (N=4, N=8, narrow output)
// driven with directed frames; a negedge monitor pops expected results on each handshake.
`timescale 1ns/1ps
module tb_qft_stream_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic signed [7:0] in_re, in_im;
  logic              mode_inv;
  logic              out_ready;
  logic [2:0]        out_valid, out_last, out_sat;
  logic signed [12:0] out_re_a, out_im_a, out_re_b, out_im_b;
  logic signed [8:0]  out_re_c, out_im_c;
  logic [1:0]         out_idx_a, out_idx_c;
  logic [2:0]         out_idx_b;

  qft_stream_engine #(.LOG2N(2), .IN_W(8), .OUT_W(13), .TW_W(12)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_re(in_re), .in_im(in_im), .mode_inv(mode_inv), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_re(out_re_a), .out_im(out_im_a), .out_idx(out_idx_a),
    .out_last(out_last[0]), .out_sat(out_sat[0]));

  qft_stream_engine #(.LOG2N(3), .IN_W(8), .OUT_W(13), .TW_W(12)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_re(in_re), .in_im(in_im), .mode_inv(mode_inv), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_re(out_re_b), .out_im(out_im_b), .out_idx(out_idx_b),
    .out_last(out_last[1]), .out_sat(out_sat[1]));

  qft_stream_engine #(.LOG2N(2), .IN_W(8), .OUT_W(9), .TW_W(12)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_re(in_re), .in_im(in_im), .mode_inv(mode_inv), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_re(out_re_c), .out_im(out_im_c), .out_idx(out_idx_c),
    .out_last(out_last[2]), .out_sat(out_sat[2]));

  typedef struct {
    int inst;
    int re;
    int im;
    int idx;
    bit last;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   xr[8], xi[8], er[8], ei[8];
  bit   es[8];

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic score(int inst, int re, int im, int idx, bit last, bit sat);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected result: inst%0d k=%0d re=%0d im=%0d, required no output", inst, idx, re, im);
    end else begin
      e = sb.pop_front();
      $display("[TB] inst%0d k=%0d re=%0d im=%0d last=%0b sat=%0b", inst, idx, re, im, last, sat);
      chk("result instance", inst, e.inst);
      chk("result re", re, e.re);
      chk("result im", im, e.im);
      chk("result idx", idx, e.idx);
      chk("result last", int'(last), int'(e.last));
      chk("result sat", int'(sat), int'(e.sat));
    end
  endtask

  always @(negedge clk) begin
    if (out_valid[0] && out_ready) score(0, int'(out_re_a), int'(out_im_a), int'(out_idx_a), out_last[0], out_sat[0]);
    if (out_valid[1] && out_ready) score(1, int'(out_re_b), int'(out_im_b), int'(out_idx_b), out_last[1], out_sat[1]);
    if (out_valid[2] && out_ready) score(2, int'(out_re_c), int'(out_im_c), int'(out_idx_c), out_last[2], out_sat[2]);
  end

  task automatic push_frame(int inst, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.inst = inst;
      e.re   = er[k];
      e.im   = ei[k];
      e.idx  = k;
      e.last = (k == n - 1);
      e.sat  = es[k];
      sb.push_back(e);
    end
  endtask

  task automatic send(int inst, int re, int im, bit inv);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    in_re = 8'(re);
    in_im = 8'(im);
    mode_inv = inv;
    in_valid[inst] = 1'b1;
    while (!done && cyc < 50) begin
      @(negedge clk);
      done = in_ready[inst];
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("send accepted", int'(done), 1);
  endtask

  // mode_inv is driven to the opposite value after x[0] to show it is ignored there
  task automatic send_frame(int inst, int n, bit inv);
    for (int i = 0; i < n; i++) send(inst, xr[i], xi[i], (i == 0) ? inv : !inv);
    in_valid[inst] = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("results outstanding", sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = '0; in_re = '0; in_im = '0; mode_inv = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid[0]), 0);
    chk("reset in_ready", int'(in_ready[0]), 1);
    chk("reset out_re", int'(out_re_a), 0);
    chk("reset out_im", int'(out_im_a), 0);
    chk("reset out_idx", int'(out_idx_a), 0);
    chk("reset out_last", int'(out_last[0]), 0);
    chk("reset out_sat", int'(out_sat[0]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // forward N=4 ramp
    xr = '{2, 4, 6, 8, 0, 0, 0, 0}; xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    er = '{20, -4, -4, -4, 0, 0, 0, 0}; ei = '{0, 4, 0, -4, 0, 0, 0, 0};
    es = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_frame(0, 4);
    send_frame(0, 4, 1'b0);
    wait_drain();

    // inverse N=4 ramp plus latency from last input edge
    er = '{20, -4, -4, -4, 0, 0, 0, 0}; ei = '{0, -4, 0, 4, 0, 0, 0, 0};
    push_frame(0, 4);
    send_frame(0, 4, 1'b1);
    cyc = 0;
    while (!out_valid[0] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency to out_valid", cyc, 17);
    wait_drain();

    // impulse N=4
    xr = '{100, 0, 0, 0, 0, 0, 0, 0}; xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    er = '{100, 100, 100, 100, 0, 0, 0, 0}; ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_frame(0, 4);
    send_frame(0, 4, 1'b0);
    wait_drain();

    // constant N=8
    xr = '{10, 10, 10, 10, 10, 10, 10, 10}; xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    er = '{80, 0, 0, 0, 0, 0, 0, 0}; ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_frame(1, 8);
    send_frame(1, 8, 1'b0);
    wait_drain();

    // positive saturation on the 9-bit output instance
    xr = '{127, 127, 127, 127, 0, 0, 0, 0}; xi = '{127, 127, 127, 127, 0, 0, 0, 0};
    er = '{255, 0, 0, 0, 0, 0, 0, 0}; ei = '{255, 0, 0, 0, 0, 0, 0, 0};
    es = '{1, 0, 0, 0, 0, 0, 0, 0};
    push_frame(2, 4);
    send_frame(2, 4, 1'b0);
    wait_drain();

    // negative saturation
    xr = '{-128, -128, -128, -128, 0, 0, 0, 0}; xi = '{-128, -128, -128, -128, 0, 0, 0, 0};
    er = '{-256, 0, 0, 0, 0, 0, 0, 0}; ei = '{-256, 0, 0, 0, 0, 0, 0, 0};
    push_frame(2, 4);
    send_frame(2, 4, 1'b0);
    wait_drain();

    // backpressure at k=1, stray in_valid during COMPUTE and OUTPUT
    xr = '{2, 4, 6, 8, 0, 0, 0, 0}; xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    er = '{20, -4, -4, -4, 0, 0, 0, 0}; ei = '{0, 4, 0, -4, 0, 0, 0, 0};
    es = '{0, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b0;
    push_frame(0, 4);
    send_frame(0, 4, 1'b0);
    in_re = 8'sd77; in_im = -8'sd77; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready in COMPUTE", int'(in_ready[0]), 0);
    in_valid[0] = 1'b0;
    cyc = 0;
    while (!out_valid[0] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp out_valid", int'(out_valid[0]), 1);
    in_valid[0] = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp hold valid", int'(out_valid[0]), 1);
      chk("bp hold idx", int'(out_idx_a), 1);
      chk("bp hold re", int'(out_re_a), -4);
      chk("bp hold im", int'(out_im_a), 4);
      chk("bp in_ready", int'(in_ready[0]), 0);
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // reset mid-COMPUTE aborts the frame
    send_frame(0, 4, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", int'(out_valid[0]), 0);
    chk("abort in_ready", int'(in_ready[0]), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort no residual valid", int'(out_valid[0]), 0);
    push_frame(0, 4);
    send_frame(0, 4, 1'b0);
    wait_drain();

    chk("scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
